// File: rtl/lisa_inst_assembler.sv
// Gathers one variable-length LISA instruction (opcode, length, body) from a
// byte stream into a zero-padded window and offers it on a valid/ready output.
module lisa_inst_assembler #(
  parameter int MAX_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [7:0]             in_byte,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MAX_BYTES*8-1:0] out_inst,
  output logic [7:0]             out_opcode,
  output logic [7:0]             out_len,
  output logic                   len_err
);

  localparam int         WIN_W   = MAX_BYTES * 8;
  localparam int         CW      = $clog2(MAX_BYTES + 1);
  localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);

  typedef enum logic [1:0] {
    S_OPC,
    S_LEN,
    S_BODY,
    S_HOLD
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIN_W-1:0]  win_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              len_err_q;

  logic len_legal;
  logic body_last;

  assign len_legal = (in_byte >= 8'd2) && (in_byte <= MAX_LEN);
  // The length byte already sits in window byte 1 while the body streams in.
  assign body_last = (int'(cnt_q) + 1) == int'(win_q[15:8]);

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below sees the pre-edge values of the registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_OPC;
      cnt_q       <= '0;
      win_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      if (flush) begin
        state_q     <= S_OPC;
        cnt_q       <= '0;
        win_q       <= '0;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_OPC: begin
            if (in_valid) begin
              win_q   <= WIN_W'(in_byte);
              state_q <= S_LEN;
            end
          end
          S_LEN: begin
            if (in_valid) begin
              if (!len_legal) begin
                len_err_q <= 1'b1;
                win_q     <= '0;
                state_q   <= S_OPC;
              end else begin
                win_q[15:8] <= in_byte;
                if (in_byte == 8'd2) begin
                  state_q     <= S_HOLD;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                end else begin
                  cnt_q   <= CW'(2);
                  state_q <= S_BODY;
                end
              end
            end
          end
          S_BODY: begin
            if (in_valid) begin
              win_q[int'(cnt_q)*8 +: 8] <= in_byte;
              cnt_q                     <= cnt_q + 1'b1;
              if (body_last) begin
                state_q     <= S_HOLD;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (out_ready) begin
              cnt_q       <= '0;
              state_q     <= S_OPC;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q     <= S_OPC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign len_err    = len_err_q;
  assign out_inst   = win_q;
  assign out_opcode = win_q[7:0];
  assign out_len    = win_q[15:8];

endmodule

// File: tb/tb_lisa_inst_assembler.sv
// Directed bench for lisa_inst_assembler: a vector table of whole instructions
// plus hand-written sequences for backpressure, stalls, flush and reset.
module tb_lisa_inst_assembler;

  localparam int MAX_BYTES = 16;
  localparam int W         = MAX_BYTES * 8;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic [7:0]   in_byte;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_inst;
  logic [7:0]   out_opcode;
  logic [7:0]   out_len;
  logic         len_err;

  lisa_inst_assembler #(.MAX_BYTES(MAX_BYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_opcode(out_opcode),
    .out_len   (out_len),
    .len_err   (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    int           n;         // bytes in the stream
    logic [W-1:0] stream;    // byte k at [8k+7:8k]
    logic         exp_err;
    logic [W-1:0] exp_inst;
  } vec_t;

  vec_t vecs[9];
  int   n_applied = 0;
  int   n_fail    = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      in_byte = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " valid_drop"}, W'(out_valid), W'(0));
    check({name, " ready_back"}, W'(in_ready), W'(1));
  endtask

  logic [W-1:0] held;
  int           gap;

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;

    vecs[0] = '{"len2",      2,  W'(128'h023A),                    1'b0, W'(128'h023A)};
    vecs[1] = '{"len5",      5,  W'(128'hCCBBAA0511),              1'b0, W'(128'hCCBBAA0511)};
    vecs[2] = '{"len1_err",  2,  W'(128'h0122),                    1'b1, W'(0)};
    vecs[3] = '{"after_err", 2,  W'(128'h0244),                    1'b0, W'(128'h0244)};
    vecs[4] = '{"len17_err", 2,  W'(128'h1122),                    1'b1, W'(0)};
    vecs[5] = '{"len16_max", 16, W'(128'h0E0D0C0B0A0908070605040302011022), 1'b0,
                W'(128'h0E0D0C0B0A0908070605040302011022)};
    vecs[6] = '{"len0_err",  2,  W'(128'h0022),                    1'b1, W'(0)};
    vecs[7] = '{"lenFF_err", 2,  W'(128'hFF66),                    1'b1, W'(0)};
    vecs[8] = '{"len3",      3,  W'(128'hA50377),                  1'b0, W'(128'hA50377)};

    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst in_ready",  W'(in_ready),  W'(1));
    check("rst out_valid", W'(out_valid), W'(0));
    check("rst out_inst",  out_inst,      W'(0));
    check("rst opc_len",   W'({out_opcode, out_len, len_err}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        check({vecs[v].name, " in_ready"}, W'(in_ready), W'(1));
        send(vecs[v].stream[8*k +: 8]);
      end
      if (vecs[v].exp_err) begin
        check({vecs[v].name, " len_err"},   W'(len_err),   W'(1));
        check({vecs[v].name, " out_valid"}, W'(out_valid), W'(0));
        @(negedge clk);
        check({vecs[v].name, " err_pulse"}, W'({len_err, out_valid}), W'(0));
      end else begin
        check({vecs[v].name, " out_valid"},  W'(out_valid),  W'(1));
        check({vecs[v].name, " out_inst"},   out_inst,       vecs[v].exp_inst);
        check({vecs[v].name, " out_opcode"}, W'(out_opcode), W'(vecs[v].exp_inst[7:0]));
        check({vecs[v].name, " out_len"},    W'(out_len),    W'(vecs[v].exp_inst[15:8]));
        check({vecs[v].name, " hold_ready"}, W'(in_ready),   W'(0));
        check({vecs[v].name, " no_err"},     W'(len_err),    W'(0));
        consume(vecs[v].name);
      end
    end

    // Backpressure: output held stable for 4 cycles with out_ready low.
    send(8'h11); send(8'h05); send(8'hAA); send(8'hBB); send(8'hCC);
    held = out_inst;
    check("bp first", held, W'(128'hCCBBAA0511));
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_byte = 8'hEE;
      @(negedge clk);
      check("bp valid",  W'(out_valid), W'(1));
      check("bp stable", out_inst,      W'(128'hCCBBAA0511));
      check("bp ready",  W'(in_ready),  W'(0));
    end
    in_valid = 1'b0;
    consume("bp");

    // Stalls inside the body must not disturb the assembled instruction.
    send(8'h90); send(8'h06);
    for (int k = 0; k < 4; k++) begin
      gap = int'($urandom_range(0, 3));
      idle(gap);
      send(8'hD1 + 8'(k));
    end
    check("gap valid", W'(out_valid), W'(1));
    check("gap inst",  out_inst,      W'(128'hD4D3D2D10690));
    consume("gap");

    // Flush after 3 of 8 bytes; the byte offered during flush is dropped.
    send(8'h33); send(8'h08); send(8'h01);
    flush = 1'b1; in_valid = 1'b1; in_byte = 8'h99;
    #1 check("flush in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush cleared", out_inst, W'(0));
    check("flush valid",   W'({out_valid, len_err}), W'(0));
    send(8'h55); send(8'h02);
    check("post_flush valid", W'(out_valid), W'(1));
    check("post_flush inst",  out_inst,      W'(128'h0255));
    consume("post_flush");

    // Asynchronous reset while holding a completed instruction.
    send(8'h12); send(8'h02);
    check("pre_rst valid", W'(out_valid), W'(1));
    #2 rst_n = 1'b0;
    #1 check("async valid", W'(out_valid), W'(0));
    check("async inst",  out_inst,     W'(0));
    check("async ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h7A); send(8'h02);
    check("after_rst inst", out_inst, W'(128'h027A));
    consume("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

// File: doc/lisa_inst_assembler.md
Name: lisa_inst_assembler

Overview:
- Sits directly upstream of the LISA fetch/decode boundary.
- Accepts the instruction byte stream one byte per cycle over a valid/ready handshake.
- Uses the same length rule as the fetch stage: byte 0 is the opcode, byte 1 is the total instruction length in bytes.
- Gathers one complete variable-length instruction into a zero-padded window, presents it on a valid/ready output, and resynchronises on illegal lengths.

Parameters:
- MAX_BYTES, 16, maximum legal instruction length in bytes; also sets the output window width (MAX_BYTES*8). Legal range 2..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous discard of all partial and held state
- in_valid  input  1  in_byte is presented this cycle
- in_byte  input  8  next byte of the instruction stream
- in_ready  output  1  block accepts in_byte this cycle
- out_valid  output  1  out_inst holds a complete instruction
- out_ready  input  1  consumer accepts out_inst this cycle
- out_inst  output  MAX_BYTES*8  instruction bytes; byte k at bits [8k+7:8k], bytes >= out_len are zero
- out_opcode  output  8  equals out_inst[7:0]
- out_len  output  8  equals out_inst[15:8]
- len_err  output  1  one-cycle pulse on rejection of an illegal length byte

Behaviour:
- Handshakes:
  - An input byte is accepted when in_valid && in_ready at a rising edge.
  - An output is consumed when out_valid && out_ready.
- Reset (rst_n low, asynchronous):
  - state=OPC, byte counter=0, window=0.
  - in_ready=1, out_valid=0, out_inst=0, out_opcode=0, out_len=0, len_err=0.
- States:
  - OPC: in_ready=1. Accept → store byte in window byte 0, clear window bytes 1..MAX_BYTES-1, go to LEN.
  - LEN: in_ready=1. Accept → evaluate len = in_byte.
    - Illegal (len<2 or len>MAX_BYTES): pulse len_err next cycle, clear window, return to OPC. Opcode and length bytes are dropped; the next accepted byte is treated as an opcode.
    - len==2: store, go to HOLD.
    - Otherwise: store, set counter=2, go to BODY.
  - BODY: in_ready=1. Accept → store at window byte[counter], counter+1. Go to HOLD when counter+1 == len.
  - HOLD: in_ready=0, out_valid=1, window stable. On out_ready → go to OPC, out_valid=0 next cycle.
- Latency and throughput:
  - out_valid rises the cycle after the last byte is accepted.
  - Minimum period per instruction is len+1 cycles (no input overlap while holding).
- Backpressure and stalls:
  - out_inst, out_opcode and out_len are stable while out_valid=1 && out_ready=0.
  - in_valid=0 in any state holds state and counter (stall, no timeout).
- Widths:
  - Length comparison is unsigned 8-bit against MAX_BYTES. No wrap is possible: the counter is sized ceil(log2(MAX_BYTES+1)) bits and never exceeds len.
  - A length byte of 0, 1, or MAX_BYTES+1..255 is illegal.
- flush:
  - Highest priority after reset. Next cycle: state=OPC, counter=0, window=0, out_valid=0, len_err=0.
  - Any byte or output handshake in the same cycle is ignored.
  - in_ready stays asserted during the flush cycle, but a byte presented then is discarded.
- Reset mid-instruction: immediate return to reset values; no partial instruction is ever emitted.
- len_err is a registered pulse, exactly one cycle per rejected length byte.

Test Plan:
- Reset, then stream 0x3A,0x02 with continuous valid → out_valid 2 cycles after first accept; out_opcode=0x3A, out_len=0x02, out_inst[15:0]=0x023A, upper bits 0; out_ready=1 → out_valid drops next cycle.
- Stream 0x11,0x05,0xAA,0xBB,0xCC → out_inst[39:0]=0xCCBBAA0511. Hold out_ready=0 for 4 cycles: out_valid and out_inst stable, in_ready=0. Then out_ready=1 → in_ready=1 next cycle.
- Stream 0x22,0x01 → len_err pulses exactly one cycle, no out_valid. Following 0x44,0x02 is assembled as opcode 0x44.
- Stream 0x22,0x11 (17 > MAX_BYTES) → len_err; 0x22,0x10 with 14 body bytes 0x01..0x0E → out_len=0x10, top byte 0x0E.
- Insert random in_valid gaps during BODY of a 6-byte instruction → identical out_inst to the gap-free run.
- Assert flush after 3 of 8 bytes, then send 0x55,0x02 → only opcode 0x55 emitted. Deassert rst_n mid-HOLD → out_valid=0 asynchronously.
